// File: rtl/pending_encoder16_pkg.sv
// Shared PMU definitions for the pending-event encoder and related arbiters.
package pending_encoder16_pkg;

    localparam int unsigned N_EVENTS_DEF = 16;
    localparam int unsigned IDX_W_DEF    = $clog2(N_EVENTS_DEF);

    typedef logic [IDX_W_DEF-1:0] idx_t;

endpackage

// File: rtl/pending_encoder16_rr_find_first.sv
// Round-robin first-set search: lowest set bit at or above start, wrapping to bit 0.
module rr_find_first #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    int unsigned k;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (int'(start) + i) % N;
            if (!found && vec[k]) begin
                found = 1'b1;
                idx   = W'(k);
            end
        end
    end

endmodule

// File: rtl/pending_encoder16.sv
// Pending-event register with round-robin index offer and per-line sticky overflow.
module pending_encoder16
    import pending_encoder16_pkg::*;
#(
    parameter int unsigned N_EVENTS = N_EVENTS_DEF,
    parameter int unsigned IDX_W    = IDX_W_DEF
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                enable_i,
    input  logic [N_EVENTS-1:0] event_i,
    input  logic                clear_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic [IDX_W-1:0]    idx_o,
    output logic [N_EVENTS-1:0] pending_o,
    output logic [N_EVENTS-1:0] overflow_o
);

    logic [N_EVENTS-1:0] pend_q, pend_d;
    logic [N_EVENTS-1:0] ovf_q, ovf_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [N_EVENTS-1:0] xfer_mask;
    logic [N_EVENTS-1:0] captured;
    logic [IDX_W-1:0]    sel_idx;
    logic                found;
    logic                xfer;

    rr_find_first #(
        .N(N_EVENTS),
        .W(IDX_W)
    ) u_find (
        .vec  (pend_q),
        .start(ptr_q),
        .idx  (sel_idx),
        .found(found)
    );

    assign valid_o    = found;
    assign idx_o      = sel_idx;
    assign pending_o  = pend_q;
    assign overflow_o = ovf_q;
    assign xfer       = found & ready_i;

    always_comb begin
        xfer_mask = '0;
        if (xfer) begin
            xfer_mask[sel_idx] = 1'b1;
        end
        captured = enable_i ? event_i : '0;

        // A capture on the bit being served re-arms it; that is not a lost event.
        pend_d = (pend_q & ~xfer_mask) | captured;
        ovf_d  = ovf_q | (captured & pend_q & ~xfer_mask);
        ptr_d  = ptr_q;
        if (xfer) begin
            ptr_d = (sel_idx == IDX_W'(N_EVENTS - 1)) ? '0 : sel_idx + 1'b1;
        end

        if (clear_i) begin
            pend_d = '0;
            ovf_d  = '0;
            ptr_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pend_q <= '0;
            ovf_q  <= '0;
            ptr_q  <= '0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            ptr_q  <= ptr_d;
        end
    end

endmodule
